// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with a per-register busy scoreboard for RAW hazard detection.
// Optional combinational write-through on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter  int XLEN     = 64,
    parameter  int NREG     = 32,
    parameter  int NREAD    = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREG),
    localparam int CW       = $clog2(NREG + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    output logic [NREG-1:0]       busy_vec,
    output logic [CW-1:0]         busy_cnt
);

    // An address is backed by real state only when in range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'({1'b0, a}) < NREG) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_ok, iss_ok;

    assign wr_ok  = wr_en  && addr_ok(wr_addr);
    assign iss_ok = iss_en && addr_ok(iss_addr);

    // Issue is applied after writeback so a same-edge issue to the same register leaves it busy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        busy_d = busy_q;
        cnt_d  = '0;
        for (int r = 0; r < NREG; r++) begin
            if (wr_ok && (wr_addr == AW'(r))) busy_d[r] = 1'b0;
            if (iss_ok && (iss_addr == AW'(r))) busy_d[r] = 1'b1;
        end
        for (int r = 0; r < NREG; r++) begin
            cnt_d = cnt_d + CW'(busy_d[r]);
        end
    end

    // NOTE: the data array is reset too -- architectural state must read zero after reset,
    // which keeps this in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
        end else if (wr_ok) begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_addr == AW'(r)) regs_q[r] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;

    // Read ports decode by comparison, so unbacked addresses fall through to the zero defaults.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NREAD; p++) begin
            for (int r = 0; r < NREG; r++) begin
                if (addr_ok(rd_addr[p*AW +: AW]) && (rd_addr[p*AW +: AW] == AW'(r))) begin
                    rd_data[p*XLEN +: XLEN] = regs_q[r];
                    rd_busy[p]              = busy_q[r];
                end
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wr_addr == rd_addr[p*AW +: AW])) begin
                rd_data[p*XLEN +: XLEN] = wr_data;
                rd_busy[p]              = iss_ok && (iss_addr == rd_addr[p*AW +: AW]);
            end
`endif
        end
    end

endmodule
